eim_mem_arbiter: RTL and testbench
==================================

EIM_MEM_ARBITER -- requirements
Module: eim_mem_arbiter

Interface
REQ-001 SHALL take parameter ADDR_W, default 8, RAM address width.
REQ-002 SHALL take parameter DATA_W, default 8, RAM data width.
REQ-003 SHALL take parameter LOCK_MAX, default 4, the maximum number of back-to-back grants to one locked requester.
REQ-004 clk  input  1  single system clock; all logic on posedge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 req_a/req_b  input  1 each  access request: A = EIM host agent, B = internal agent.
REQ-007 we_a/we_b  input  1 each  1 = write, 0 = read.
REQ-008 addr_a/addr_b  input  ADDR_W each  target address.
REQ-009 wdata_a/wdata_b  input  DATA_W each  write data.
REQ-010 lock_a/lock_b  input  1 each  requests retention of the grant for the next transaction.
REQ-011 ack_a/ack_b  output  1 each  one-cycle completion pulse.
REQ-012 rdata_a/rdata_b  output  DATA_W each  read data, valid while the matching ack is high.
REQ-013 mem_en, mem_we  output  1 each  single-port RAM enable and write strobe.
REQ-014 mem_addr, mem_wdata  output  ADDR_W, DATA_W  RAM address and write data.
REQ-015 mem_rdata  input  DATA_W  RAM read data, registered, valid one cycle after mem_en.
REQ-016 busy  output  1  high in any state other than IDLE.

Function
REQ-017 SHALL implement FSM states IDLE -> ISSUE -> CAPTURE -> IDLE; ISSUE and CAPTURE SHALL each last exactly one cycle.
REQ-018 In IDLE, at a clock edge where at least one eligible req is high, the arbiter SHALL select a winner, register its command onto mem_*, and enter ISSUE.
REQ-019 mem_en SHALL be high only in ISSUE; mem_we SHALL equal the winner's we; mem_addr and mem_wdata SHALL hold the winner's values; mem_* SHALL be 0 elsewhere.
REQ-020 On the edge ending CAPTURE, the arbiter SHALL register mem_rdata into the winner's rdata, pulse that ack for one cycle, and return to IDLE.
REQ-021 Latency: req sampled in IDLE at edge N gives mem_en in cycle N..N+1 and ack high in cycle N+2..N+3; throughput SHALL be one transaction per 3 cycles.
REQ-022 On a write, rdata SHALL still capture mem_rdata; the requester ignores it.
REQ-023 A requester whose ack is high in the current cycle SHALL be ineligible at that IDLE edge; this prevents re-granting a stale request.
REQ-024 Requester obligations: hold we/addr/wdata stable from req assertion until ack; deassert req or present a new request the cycle after ack.
REQ-025 Arbitration SHALL be round-robin with a last-winner pointer.
REQ-026 On a tie, the requester not equal to last_winner SHALL win; last_winner SHALL reset to B, so A wins the first tie.
REQ-027 Lock: if the winner had its lock input high when granted and it requests again, it SHALL win the next arbitration regardless of the round-robin pointer.
REQ-028 lock_cnt SHALL count consecutive locked grants to one requester.
REQ-029 When lock_cnt reaches LOCK_MAX and the other requester is waiting, the lock SHALL be overridden and the other requester SHALL win; lock_cnt SHALL then clear.
REQ-030 lock_cnt SHALL clear on any grant to the other requester, or on a grant with lock low.
REQ-031 A req that drops before being granted SHALL be ignored; a req that drops mid-transaction SHALL not abort it, and the ack is still issued.
REQ-032 Address wrap: no range check; the full 2^ADDR_W space SHALL pass through unchanged.

Reset
REQ-033 While rst is high, the FSM SHALL be forced to IDLE.
REQ-034 While rst is high: ack_a/b, mem_en, mem_we and busy SHALL be 0; rdata_a/b, mem_addr and mem_wdata SHALL be 0; lock_cnt SHALL be 0; last_winner SHALL be B.
REQ-035 Reset asserted mid-transaction SHALL abandon the transaction with no ack.
REQ-036 A write whose mem_en was already sampled by the RAM before reset SHALL be considered complete.
REQ-037 After rst deasserts, the first arbitration SHALL occur at the first clk edge that finds an eligible req in IDLE.

Verification
REQ-038 Single read: RAM[0x10]=0x5A; req_a read 0x10 at edge N -> mem_en cycle N+1, ack_a with rdata_a=0x5A cycle N+3, ack_b never.
REQ-039 Tie after reset: req_a write 0x01<-0x11 and req_b write 0x02<-0x22 both held -> A granted first, then B; RAM[1]=0x11, RAM[2]=0x22; acks 3 cycles apart.
REQ-040 Round-robin under saturation: req_a and req_b continuously re-requesting, no lock -> grants alternate A,B,A,B over 8 transactions.
REQ-041 Lock starvation bound: lock_a=1, req_a continuous, req_b held (LOCK_MAX=4) -> four A grants, then B, then A resumes.
REQ-042 Reset mid-op: rst pulsed during CAPTURE of B read -> no ack_b, all outputs 0, busy=0; next tie after release grants A.
REQ-043 Stale-req guard: req_a held high one cycle past ack_a with B idle -> no second A transaction starts at that edge.

Source files
------------

// File: rtl/eim_mem_arbiter.sv
// eim_mem_arbiter: round-robin arbiter with a bounded lock, giving the EIM host (A) and an internal
// agent (B) shared access to a single-port RAM with a registered read port.
module eim_mem_arbiter #(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 8,
  parameter int LOCK_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_a,
  input  logic              req_b,
  input  logic              we_a,
  input  logic              we_b,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [ADDR_W-1:0] addr_b,
  input  logic [DATA_W-1:0] wdata_a,
  input  logic [DATA_W-1:0] wdata_b,
  input  logic              lock_a,
  input  logic              lock_b,
  output logic              ack_a,
  output logic              ack_b,
  output logic [DATA_W-1:0] rdata_a,
  output logic [DATA_W-1:0] rdata_b,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam int CNT_W = $clog2(LOCK_MAX + 1) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LOCK_MAX);

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE} state_t;

  state_t           state_q, state_d;
  logic             last_b_q;    // last_winner: 1 = B
  logic             win_b_q;     // owner of the transaction in flight
  logic             lock_vld_q;  // last winner was granted with its lock high
  logic [CNT_W-1:0] lock_cnt_q, lock_cnt_d;

  logic elig_a, elig_b, own_elig, oth_elig, own_ack, capped;
  logic grant, grant_b, win_lock;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c >= CNT_MAX) ? c : c + 1'b1;
  endfunction

  always_comb begin
    elig_a   = req_a & ~ack_a;
    elig_b   = req_b & ~ack_b;
    own_elig = last_b_q ? elig_b : elig_a;
    oth_elig = last_b_q ? elig_a : elig_b;
    own_ack  = last_b_q ? ack_b : ack_a;
    capped   = (lock_cnt_q >= CNT_MAX);
    grant    = 1'b0;
    grant_b  = 1'b0;
    state_d  = state_q;
    case (state_q)
      IDLE: begin
        // A locked owner cannot re-request during its own ack cycle, so that cycle is
        // reserved for it rather than handed to the other agent.
        if (lock_vld_q && !(capped && oth_elig)) begin
          if (own_elig) begin
            grant   = 1'b1;
            grant_b = last_b_q;
          end else if (!own_ack && oth_elig) begin
            grant   = 1'b1;
            grant_b = ~last_b_q;
          end
        end else if (elig_a && elig_b) begin
          grant   = 1'b1;
          grant_b = ~last_b_q;
        end else if (elig_a || elig_b) begin
          grant   = 1'b1;
          grant_b = elig_b;
        end
        if (grant) state_d = ISSUE;
      end
      ISSUE:   state_d = CAPTURE;
      CAPTURE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    win_lock = grant_b ? lock_b : lock_a;
    if (!win_lock)
      lock_cnt_d = '0;
    else if ((grant_b == last_b_q) && lock_vld_q)
      lock_cnt_d = sat_inc(lock_cnt_q);
    else
      lock_cnt_d = CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      last_b_q   <= 1'b1;
      win_b_q    <= 1'b0;
      lock_vld_q <= 1'b0;
      lock_cnt_q <= '0;
      ack_a      <= 1'b0;
      ack_b      <= 1'b0;
      rdata_a    <= '0;
      rdata_b    <= '0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      state_q <= state_d;
      ack_a   <= 1'b0;
      ack_b   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (grant) begin
            mem_en     <= 1'b1;
            mem_we     <= grant_b ? we_b : we_a;
            mem_addr   <= grant_b ? addr_b : addr_a;
            mem_wdata  <= grant_b ? wdata_b : wdata_a;
            win_b_q    <= grant_b;
            last_b_q   <= grant_b;
            lock_vld_q <= win_lock;
            lock_cnt_q <= lock_cnt_d;
          end
        end
        ISSUE: begin
          mem_en    <= 1'b0;
          mem_we    <= 1'b0;
          mem_addr  <= '0;
          mem_wdata <= '0;
        end
        CAPTURE: begin
          // Writes capture too; the requester simply ignores rdata.
          if (win_b_q) begin
            ack_b   <= 1'b1;
            rdata_b <= mem_rdata;
          end else begin
            ack_a   <= 1'b1;
            rdata_a <= mem_rdata;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_eim_mem_arbiter.sv
// Directed testbench for eim_mem_arbiter with a behavioural registered-read RAM.
module tb_eim_mem_arbiter;

  logic       clk, rst;
  logic       req_a, req_b, we_a, we_b, lock_a, lock_b;
  logic [7:0] addr_a, addr_b, wdata_a, wdata_b;
  logic       ack_a, ack_b, mem_en, mem_we, busy;
  logic [7:0] rdata_a, rdata_b, mem_addr, mem_wdata, mem_rdata;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] ram [0:255];
  logic       pre_we;
  logic [7:0] pre_addr, pre_data;
  int         ack_log[$];

  eim_mem_arbiter #(.ADDR_W(8), .DATA_W(8), .LOCK_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .req_a(req_a), .req_b(req_b), .we_a(we_a), .we_b(we_b),
    .addr_a(addr_a), .addr_b(addr_b), .wdata_a(wdata_a), .wdata_b(wdata_b),
    .lock_a(lock_a), .lock_b(lock_b),
    .ack_a(ack_a), .ack_b(ack_b), .rdata_a(rdata_a), .rdata_b(rdata_b),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (pre_we) ram[pre_addr] <= pre_data;
    else if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      mem_rdata <= ram[mem_addr];
    end
  end

  always @(negedge clk) begin
    if (ack_a) ack_log.push_back(0);
    if (ack_b) ack_log.push_back(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req_a = 0; req_b = 0; we_a = 0; we_b = 0; lock_a = 0; lock_b = 0;
    addr_a = 0; addr_b = 0; wdata_a = 0; wdata_b = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1;
    tick();
    tick();
    rst = 0;
  endtask

  task automatic preload(input logic [7:0] a, input logic [7:0] d);
    pre_we = 1; pre_addr = a; pre_data = d;
    tick();
    pre_we = 0;
  endtask

  task automatic drain();
    idle_inputs();
    for (int i = 0; i < 6; i++) tick();
  endtask

  task automatic test_reset();
    rst = 1;
    #1;
    n_vec++; if ({ack_a, ack_b, mem_en, mem_we, busy} !== 5'b0) begin n_err++; $display("FAIL reset_ctrl: got %b expected 00000", {ack_a, ack_b, mem_en, mem_we, busy}); end
    n_vec++; if (rdata_a !== 8'h00) begin n_err++; $display("FAIL reset_rdata_a: got %h expected 00", rdata_a); end
    n_vec++; if (rdata_b !== 8'h00) begin n_err++; $display("FAIL reset_rdata_b: got %h expected 00", rdata_b); end
    n_vec++; if ({mem_addr, mem_wdata} !== 16'h0) begin n_err++; $display("FAIL reset_mem_bus: got %h expected 0000", {mem_addr, mem_wdata}); end
    tick();
    rst = 0;
  endtask

  task automatic test_single_read();
    req_a = 1; we_a = 0; addr_a = 8'h10;
    tick();
    n_vec++; if ({mem_en, mem_we, busy} !== 3'b101) begin n_err++; $display("FAIL rd_issue_ctrl: got %b expected 101", {mem_en, mem_we, busy}); end
    n_vec++; if (mem_addr !== 8'h10) begin n_err++; $display("FAIL rd_issue_addr: got %h expected 10", mem_addr); end
    tick();
    n_vec++; if ({mem_en, busy, ack_a} !== 3'b010) begin n_err++; $display("FAIL rd_capture_ctrl: got %b expected 010", {mem_en, busy, ack_a}); end
    tick();
    n_vec++; if ({ack_a, ack_b, busy} !== 3'b100) begin n_err++; $display("FAIL rd_ack: got %b expected 100", {ack_a, ack_b, busy}); end
    n_vec++; if (rdata_a !== 8'h5A) begin n_err++; $display("FAIL rd_rdata_a: got %h expected 5a", rdata_a); end
    req_a = 0;
    tick();
    n_vec++; if ({ack_a, ack_b, busy} !== 3'b000) begin n_err++; $display("FAIL rd_ack_pulse: got %b expected 000", {ack_a, ack_b, busy}); end
  endtask

  task automatic test_addr_wrap();
    req_a = 1; we_a = 0; addr_a = 8'hFF;
    tick();
    n_vec++; if (mem_addr !== 8'hFF) begin n_err++; $display("FAIL wrap_addr: got %h expected ff", mem_addr); end
    tick();
    tick();
    n_vec++; if ({ack_a, rdata_a} !== {1'b1, 8'hC3}) begin n_err++; $display("FAIL wrap_rdata: got %b/%h expected 1/c3", ack_a, rdata_a); end
    drain();
  endtask

  task automatic test_tie_write();
    do_reset();
    req_a = 1; we_a = 1; addr_a = 8'h01; wdata_a = 8'h11;
    req_b = 1; we_b = 1; addr_b = 8'h02; wdata_b = 8'h22;
    tick();
    n_vec++; if ({mem_en, mem_we, mem_addr, mem_wdata} !== {2'b11, 8'h01, 8'h11}) begin n_err++; $display("FAIL tie_first: got %b%b %h %h expected 11 01 11", mem_en, mem_we, mem_addr, mem_wdata); end
    tick();
    tick();
    n_vec++; if ({ack_a, ack_b} !== 2'b10) begin n_err++; $display("FAIL tie_ack_a: got %b expected 10", {ack_a, ack_b}); end
    req_a = 0;
    tick();
    n_vec++; if ({mem_en, mem_we, mem_addr, mem_wdata} !== {2'b11, 8'h02, 8'h22}) begin n_err++; $display("FAIL tie_second: got %b%b %h %h expected 11 02 22", mem_en, mem_we, mem_addr, mem_wdata); end
    tick();
    tick();
    n_vec++; if ({ack_a, ack_b} !== 2'b01) begin n_err++; $display("FAIL tie_ack_b: got %b expected 01", {ack_a, ack_b}); end
    req_b = 0;
    tick();
    n_vec++; if (ram[1] !== 8'h11) begin n_err++; $display("FAIL tie_ram1: got %h expected 11", ram[1]); end
    n_vec++; if (ram[2] !== 8'h22) begin n_err++; $display("FAIL tie_ram2: got %h expected 22", ram[2]); end
    drain();
  endtask

  task automatic test_round_robin();
    int base;
    do_reset();
    base = ack_log.size();
    req_a = 1; addr_a = 8'h10; req_b = 1; addr_b = 8'h20;
    for (int i = 0; i < 80 && (ack_log.size() - base) < 8; i++) tick();
    n_vec++;
    if ((ack_log.size() - base) < 8) begin
      n_err++; $display("FAIL rr_timeout: got %0d acks expected 8", ack_log.size() - base);
    end else begin
      for (int i = 0; i < 8; i++) begin
        n_vec++; if (ack_log[base + i] != (i % 2)) begin n_err++; $display("FAIL rr_order[%0d]: got %0d expected %0d", i, ack_log[base + i], i % 2); end
      end
    end
    drain();
  endtask

  task automatic test_lock_bound();
    int base;
    int exp_seq[6];
    exp_seq = '{0, 0, 0, 0, 1, 0};
    do_reset();
    base = ack_log.size();
    req_a = 1; lock_a = 1; addr_a = 8'h10; req_b = 1; addr_b = 8'h20;
    for (int i = 0; i < 100 && (ack_log.size() - base) < 6; i++) tick();
    n_vec++;
    if ((ack_log.size() - base) < 6) begin
      n_err++; $display("FAIL lock_timeout: got %0d acks expected 6", ack_log.size() - base);
    end else begin
      for (int i = 0; i < 6; i++) begin
        n_vec++; if (ack_log[base + i] != exp_seq[i]) begin n_err++; $display("FAIL lock_order[%0d]: got %0d expected %0d", i, ack_log[base + i], exp_seq[i]); end
      end
    end
    drain();
  endtask

  task automatic test_reset_mid_op();
    do_reset();
    req_b = 1; we_b = 0; addr_b = 8'h20;
    tick();
    tick();
    rst = 1;
    #1;
    n_vec++; if ({busy, mem_en, mem_we, ack_b} !== 4'b0000) begin n_err++; $display("FAIL rstmid_ctrl: got %b expected 0000", {busy, mem_en, mem_we, ack_b}); end
    n_vec++; if ({rdata_b, mem_addr} !== 16'h0) begin n_err++; $display("FAIL rstmid_data: got %h expected 0000", {rdata_b, mem_addr}); end
    tick();
    n_vec++; if ({ack_b, busy} !== 2'b00) begin n_err++; $display("FAIL rstmid_no_ack: got %b expected 00", {ack_b, busy}); end
    req_a = 1; we_a = 0; addr_a = 8'h30;
    rst = 0;
    tick();
    n_vec++; if ({mem_en, mem_addr} !== {1'b1, 8'h30}) begin n_err++; $display("FAIL rstmid_tie_a: got %b %h expected 1 30", mem_en, mem_addr); end
    tick();
    tick();
    n_vec++; if ({ack_a, ack_b, rdata_a} !== {2'b10, 8'h88}) begin n_err++; $display("FAIL rstmid_ack_a: got %b%b %h expected 10 88", ack_a, ack_b, rdata_a); end
    drain();
  endtask

  task automatic test_stale_req();
    do_reset();
    req_a = 1; we_a = 0; addr_a = 8'h10;
    tick();
    tick();
    tick();
    n_vec++; if (ack_a !== 1'b1) begin n_err++; $display("FAIL stale_ack: got %b expected 1", ack_a); end
    tick();
    n_vec++; if ({busy, mem_en} !== 2'b00) begin n_err++; $display("FAIL stale_regrant: got %b expected 00", {busy, mem_en}); end
    req_a = 0;
    tick();
    n_vec++; if ({busy, ack_a} !== 2'b00) begin n_err++; $display("FAIL stale_idle: got %b expected 00", {busy, ack_a}); end
    drain();
  endtask

  initial begin
    rst = 1; pre_we = 0; pre_addr = 0; pre_data = 0; mem_rdata = 0;
    idle_inputs();
    preload(8'h10, 8'h5A);
    preload(8'hFF, 8'hC3);
    preload(8'h01, 8'h00);
    preload(8'h02, 8'h00);
    preload(8'h20, 8'h77);
    preload(8'h30, 8'h88);
    test_reset();
    test_single_read();
    test_addr_wrap();
    test_tie_write();
    test_round_robin();
    test_lock_bound();
    test_reset_mid_op();
    test_stale_req();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
